rom_nibble_arbiter: RTL and testbench



---
 rtl/rom_nibble_arbiter.sv | 140 ++++++++++++++
 tb/tb_rom_nibble_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_nibble_arbiter.sv
// rom_nibble_arbiter: round-robin arbiter and read sequencer that lets two
// client ports share one 256x4 registered-output PROM. Each port may fetch
// a single nibble or a byte assembled from two consecutive nibbles.
module rom_nibble_arbiter (
    input  logic       clk,
    input  logic       reset,

    // Port A
    input  logic       a_req,
    input  logic [7:0] a_addr,
    input  logic       a_wide,
    output logic       a_ack,
    output logic [7:0] a_data,

    // Port B
    input  logic       b_req,
    input  logic [7:0] b_addr,
    input  logic       b_wide,
    output logic       b_ack,
    output logic [7:0] b_data,

    // PROM side
    output logic [7:0] rom_addr,
    output logic       rom_cs,
    input  logic [3:0] rom_dout,

    output logic       busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StCapLo = 2'd2,
        StCapHi = 2'd3
    } state_e;

    state_e     state_q;
    logic       owner_q;       // 0 = A, 1 = B
    logic       wide_q;
    logic       last_grant_q;  // 0 = A, 1 = B
    logic [3:0] lo_q;

    logic a_elig;
    logic b_elig;
    logic grant_a;
    logic grant_b;

    // Arbitration: a port that is being acked this cycle sits out one round,
    // and on a tie the port not granted last time wins.
    always_comb begin
        a_elig  = a_req & ~a_ack;
        b_elig  = b_req & ~b_ack;
        grant_a = a_elig & (~b_elig | last_grant_q);
        grant_b = b_elig & ~grant_a;
    end

    // Sequencer FSM; every output is registered so no input reaches an output
    // combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            wide_q       <= 1'b0;
            last_grant_q <= 1'b1;
            lo_q         <= 4'h0;
            rom_addr     <= 8'h00;
            rom_cs       <= 1'b0;
            busy         <= 1'b0;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            a_data       <= 8'h00;
            b_data       <= 8'h00;
        end else begin
            // Acks are single-cycle pulses unless re-asserted below.
            a_ack <= 1'b0;
            b_ack <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (grant_a || grant_b) begin
                        owner_q      <= grant_b;
                        last_grant_q <= grant_b;
                        rom_addr     <= grant_b ? b_addr : a_addr;
                        wide_q       <= grant_b ? b_wide : a_wide;
                        rom_cs       <= 1'b1;
                        busy         <= 1'b1;
                        state_q      <= StIssue;
                    end
                end

                StIssue: begin
                    // PROM latches rom[addr] at this edge; queue the high
                    // nibble address (8-bit wrap is intentional).
                    if (wide_q) begin
                        rom_addr <= rom_addr + 8'd1;
                    end
                    state_q <= StCapLo;
                end

                StCapLo: begin
                    lo_q <= rom_dout;
                    if (!wide_q) begin
                        if (owner_q) begin
                            b_data <= {4'h0, rom_dout};
                            b_ack  <= 1'b1;
                        end else begin
                            a_data <= {4'h0, rom_dout};
                            a_ack  <= 1'b1;
                        end
                        rom_cs  <= 1'b0;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StCapHi;
                    end
                end

                StCapHi: begin
                    if (owner_q) begin
                        b_data <= {rom_dout, lo_q};
                        b_ack  <= 1'b1;
                    end else begin
                        a_data <= {rom_dout, lo_q};
                        a_ack  <= 1'b1;
                    end
                    rom_cs  <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    rom_cs  <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_nibble_arbiter.sv
// Self-checking bench for rom_nibble_arbiter with a behavioural PROM model.
module tb_rom_nibble_arbiter;

    logic       clk;
    logic       reset;
    logic       a_req, a_wide, a_ack;
    logic [7:0] a_addr, a_data;
    logic       b_req, b_wide, b_ack;
    logic [7:0] b_addr, b_data;
    logic [7:0] rom_addr;
    logic       rom_cs;
    logic [3:0] rom_dout;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    bit         ack_order[$];
    logic [7:0] last_data[2];

    rom_nibble_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .a_req    (a_req),
        .a_addr   (a_addr),
        .a_wide   (a_wide),
        .a_ack    (a_ack),
        .a_data   (a_data),
        .b_req    (b_req),
        .b_addr   (b_addr),
        .b_wide   (b_wide),
        .b_ack    (b_ack),
        .b_data   (b_data),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_dout (rom_dout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PROM contents
    function automatic logic [3:0] prom(input logic [7:0] a);
        case (a)
            8'h00: prom = 4'h0;
            8'h02: prom = 4'h4;
            8'h03: prom = 4'h3;
            8'h09: prom = 4'h7;
            8'h0B: prom = 4'hD;
            8'h0C: prom = 4'hC;
            8'hFE: prom = 4'hD;
            8'hFF: prom = 4'h0;
            default: prom = a[3:0] ^ a[7:4] ^ 4'h5;
        endcase
    endfunction

    // Registered-output PROM, one-cycle latency
    always @(posedge clk) begin
        if (rom_cs) rom_dout <= prom(rom_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare each ack against the expected value queued at drive time
    always @(negedge clk) begin
        if (a_ack || b_ack) check("acks coincide", {31'd0, a_ack & b_ack}, 32'd0);
        if (a_ack === 1'b1) begin
            ack_order.push_back(1'b0);
            if (exp_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected a_ack: got 1, expected 0 (data %0h)", a_data);
            end else begin
                check("a_data", {24'd0, a_data}, {24'd0, exp_a.pop_front()});
            end
        end
        if (b_ack === 1'b1) begin
            ack_order.push_back(1'b1);
            if (exp_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected b_ack: got 1, expected 0 (data %0h)", b_data);
            end else begin
                check("b_data", {24'd0, b_data}, {24'd0, exp_b.pop_front()});
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, " a_ack"},    {31'd0, a_ack},  32'd0);
        check({tag, " b_ack"},    {31'd0, b_ack},  32'd0);
        check({tag, " a_data"},   {24'd0, a_data}, 32'd0);
        check({tag, " b_data"},   {24'd0, b_data}, 32'd0);
        check({tag, " rom_addr"}, {24'd0, rom_addr}, 32'd0);
        check({tag, " rom_cs"},   {31'd0, rom_cs}, 32'd0);
        check({tag, " busy"},     {31'd0, busy},   32'd0);
    endtask

    // One complete access on one port, with latency and address-sequence checks
    task automatic run_req(input bit port, input logic [7:0] addr, input bit wide,
                           input logic [7:0] exp, input int exp_lat, input string name);
        logic [7:0] seen[3];
        logic [7:0] addr_hi;
        int         ns;
        int         lat;
        bit         got;
        ns  = 0;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 3; i++) seen[i] = 8'hxx;
        addr_hi = addr + 8'd1;
        @(negedge clk);
        if (port) begin
            b_req = 1'b1; b_addr = addr; b_wide = wide; exp_b.push_back(exp);
        end else begin
            a_req = 1'b1; a_addr = addr; a_wide = wide; exp_a.push_back(exp);
        end
        for (int c = 1; c <= 12 && !got; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) check({name, " busy after grant"}, {31'd0, busy & rom_cs}, 32'd1);
            if (rom_cs === 1'b1 && ns < 3) begin
                seen[ns] = rom_addr;
                ns++;
            end
            if ((port ? b_ack : a_ack) === 1'b1) begin
                got = 1'b1;
                lat = c;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout: no ack within 12 cycles, expected %0d", name, exp_lat);
            if (port) void'(exp_b.pop_back()); else void'(exp_a.pop_back());
        end else begin
            check({name, " latency"}, lat, exp_lat);
        end
        check({name, " rom_addr first"}, {24'd0, seen[0]}, {24'd0, addr});
        check({name, " rom_addr second"}, {24'd0, seen[1]}, {24'd0, wide ? addr_hi : addr});
        check({name, " other port data held"},
              {24'd0, port ? a_data : b_data}, {24'd0, last_data[~port]});
        last_data[port] = exp;
        @(posedge clk);
        @(negedge clk);
        check({name, " ack single pulse"}, {31'd0, port ? b_ack : a_ack}, 32'd0);
    endtask

    typedef struct {
        bit         port;
        logic [7:0] addr;
        bit         wide;
        logic [7:0] exp;
        int         lat;
    } vec_t;

    vec_t vecs[8];
    int   nack;
    bit   exp_order[4];

    initial begin
        reset = 1'b1;
        a_req = 1'b0; a_addr = 8'h00; a_wide = 1'b0;
        b_req = 1'b0; b_addr = 8'h00; b_wide = 1'b0;

        vecs[0] = '{1'b0, 8'h09, 1'b0, 8'h07, 3};
        vecs[1] = '{1'b1, 8'h0B, 1'b1, 8'hCD, 4};
        vecs[2] = '{1'b0, 8'hFE, 1'b1, 8'h0D, 4};
        vecs[3] = '{1'b0, 8'hFF, 1'b1, 8'h00, 4};
        vecs[4] = '{1'b1, 8'h09, 1'b0, 8'h07, 3};
        vecs[5] = '{1'b0, 8'h0B, 1'b0, 8'h0D, 3};
        vecs[6] = '{1'b1, 8'h40, 1'b1, {prom(8'h41), prom(8'h40)}, 4};
        vecs[7] = '{1'b0, 8'h7F, 1'b0, {4'h0, prom(8'h7F)}, 3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;

        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i].port, vecs[i].addr, vecs[i].wide, vecs[i].exp, vecs[i].lat,
                    $sformatf("vec%0d", i));
        end

        // Contention: both ports held high from reset, narrow requests
        @(negedge clk);
        reset = 1'b1;
        exp_a.delete();
        exp_b.delete();
        a_req = 1'b1; a_addr = 8'h02; a_wide = 1'b0;
        b_req = 1'b1; b_addr = 8'h03; b_wide = 1'b0;
        exp_a.push_back(8'h04); exp_a.push_back(8'h04);
        exp_b.push_back(8'h03); exp_b.push_back(8'h03);
        @(posedge clk);
        @(negedge clk);
        ack_order.delete();
        reset = 1'b0;
        nack = 0;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_ack === 1'b1) nack++;
            if (b_ack === 1'b1) nack++;
            if (nack >= 4) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("contention ack count", ack_order.size(), 4);
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            if (i < ack_order.size())
                check($sformatf("contention grant %0d", i), {31'd0, ack_order[i]},
                      {31'd0, exp_order[i]});
        end
        last_data[0] = 8'h04;
        last_data[1] = 8'h03;

        // Reset while a wide access is in CAP_LO
        @(negedge clk);
        a_req = 1'b1; a_addr = 8'h0B; a_wide = 1'b1;
        exp_a.push_back(8'hCD);
        @(posedge clk);   // grant -> ISSUE
        @(posedge clk);   // -> CAP_LO
        @(negedge clk);
        check("midreset busy before reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        a_req = 1'b0;
        exp_a.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("midreset");
        reset = 1'b0;
        last_data[0] = 8'h00;
        last_data[1] = 8'h00;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("midreset idle", {31'd0, busy}, 32'd0);
        run_req(1'b0, 8'h0B, 1'b1, 8'hCD, 4, "rerequest");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
